// File: rtl/cam_tx_gen.sv
// Camera-bus transmitter: frames pixels onto PCLK/VSYNC/HREF/D as high/low nibbles.
// Optional test-pattern source is built only when CAM_TX_PATTERN_EN is defined.
module cam_tx_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int V_FP        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pattern_sel,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       PCLK,
    output logic       VSYNC,
    output logic       HREF,
    output logic [3:0] D,
    output logic       frame_done,
    output logic       underflow
);
    localparam int SLOTS   = 2 * H_ACTIVE + H_BLANK;
    localparam int VMAX_AB = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int VMAX_CD = (V_BP > V_FP) ? V_BP : V_FP;
    localparam int VMAX    = (VMAX_AB > VMAX_CD) ? VMAX_AB : VMAX_CD;
    localparam int SW      = $clog2(SLOTS + 1);
    localparam int LW      = $clog2(VMAX + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [SW-1:0] HREF_END  = SW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {S_IDLE, S_VS, S_VBP, S_ACT, S_VFP} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   line_q, line_d, last_line_s;
    logic [SW-1:0]   slot_q, slot_d;
    logic            prime_q, pclk_q, vsync_q, href_q, ready_q, done_q, uflow_q;
    logic [3:0]      d_q, low_q;
    logic            frame_end_s, href_s, pat_mode_s;
    logic [7:0]      pat_pix_s, stream_pix_s;

    // Position of the slot that the next PCLK falling edge will put on the bus.
    // prime_q marks a fresh frame whose first slot is already addressed.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        slot_d      = slot_q;
        frame_end_s = 1'b0;
        case (state_q)
            S_VS:    last_line_s = LW'(VSYNC_LINES - 1);
            S_VBP:   last_line_s = LW'(V_BP - 1);
            S_ACT:   last_line_s = LW'(V_ACTIVE - 1);
            S_VFP:   last_line_s = LW'(V_FP - 1);
            default: last_line_s = {LW{1'b0}};
        endcase
        if (prime_q) begin
            slot_d = slot_q;
        end else if (slot_q != SLOT_LAST) begin
            slot_d = slot_q + SW'(1);
        end else if (line_q != last_line_s) begin
            slot_d = {SW{1'b0}};
            line_d = line_q + LW'(1);
        end else begin
            slot_d = {SW{1'b0}};
            line_d = {LW{1'b0}};
            case (state_q)
                S_VS:  state_d = S_VBP;
                S_VBP: state_d = S_ACT;
                S_ACT: state_d = S_VFP;
                S_VFP: begin
                    frame_end_s = 1'b1;
                    state_d     = enable ? S_VS : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign href_s       = (state_d == S_ACT) && (slot_d < HREF_END);
    assign stream_pix_s = pix_valid ? pix_data : 8'h00;

`ifdef CAM_TX_PATTERN_EN
    assign pat_mode_s = pattern_sel;
    assign pat_pix_s  = {4'(slot_d >> 1), 4'(line_d)};
`else
    assign pat_mode_s = pattern_sel & 1'b0;
    assign pat_pix_s  = 8'h00;
`endif

    // Frame FSM: PCLK toggles each clk; bus outputs and counters move on PCLK 1->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= {LW{1'b0}};
            slot_q  <= {SW{1'b0}};
            prime_q <= 1'b0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 4'h0;
            low_q   <= 4'h0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            if (state_q == S_IDLE) begin
                pclk_q <= 1'b0;
                if (enable) begin
                    state_q <= S_VS;
                    line_q  <= {LW{1'b0}};
                    slot_q  <= {SW{1'b0}};
                    prime_q <= 1'b1;
                    pclk_q  <= 1'b1;
                end
            end else if (!pclk_q) begin
                pclk_q  <= 1'b1;
                // Request the pixel one clk before its high nibble goes out.
                ready_q <= href_s && !slot_d[0] && !pat_mode_s;
            end else begin
                pclk_q  <= 1'b0;
                prime_q <= 1'b0;
                state_q <= state_d;
                line_q  <= line_d;
                slot_q  <= slot_d;
                done_q  <= frame_end_s;
                vsync_q <= (state_d == S_VS);
                href_q  <= href_s;
                if (!href_s) begin
                    d_q <= 4'h0;
                end else if (slot_d[0]) begin
                    d_q <= low_q;
                end else if (pat_mode_s) begin
                    d_q   <= pat_pix_s[7:4];
                    low_q <= pat_pix_s[3:0];
                end else begin
                    d_q   <= stream_pix_s[7:4];
                    low_q <= stream_pix_s[3:0];
                    if (!pix_valid) begin
                        uflow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign PCLK       = pclk_q;
    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign D          = d_q;
    assign pix_ready  = ready_q;
    assign frame_done = done_q;
    assign underflow  = uflow_q;

endmodule

// File: tb/tb_cam_tx_gen.sv
// Directed bench for cam_tx_gen with a 4x2 active frame (10 slots/line, 5 lines/frame).
module tb_cam_tx_gen;
    localparam int NS = 260;

    logic       clk = 1'b0;
    logic       rst, enable, pattern_sel, pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready, PCLK, VSYNC, HREF, frame_done, underflow;
    logic [3:0] D;

    always #5 clk = ~clk;

    cam_tx_gen #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .VSYNC_LINES(1), .V_BP(1), .V_FP(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .frame_done(frame_done), .underflow(underflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic       s_pclk [NS];
    logic       s_vs   [NS];
    logic       s_href [NS];
    logic       s_rdy  [NS];
    logic       s_fd   [NS];
    logic       s_uf   [NS];
    logic [3:0] s_d    [NS];
    logic [3:0] nib    [64];
    int         n_nib;
    logic [7:0] pix_tab [16];
    int         pidx, drop_idx;

    // Run n cycles sampling on negedge; pixel source advances on each ready cycle.
    task automatic run(input int ncyc, input int en_drop_at);
        for (int i = 0; i < ncyc; i++) begin
            pix_data  = pix_tab[pidx % 16];
            pix_valid = (pidx != drop_idx);
            @(negedge clk);
            s_pclk[i] = PCLK; s_vs[i] = VSYNC; s_href[i] = HREF;
            s_rdy[i] = pix_ready; s_fd[i] = frame_done; s_uf[i] = underflow; s_d[i] = D;
            @(posedge clk); #1;
            if (s_rdy[i]) pidx++;
            if (i + 1 == en_drop_at) enable = 1'b0;
        end
    endtask

    task automatic get_nibbles(input int lim);
        n_nib = 0;
        for (int i = 1; i < lim; i++)
            if (s_href[i] && !s_pclk[i] && n_nib < 64) begin
                nib[n_nib] = s_d[i];
                n_nib++;
            end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; pattern_sel = 1'b0;
        pidx = 0; drop_idx = -1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int ones;
        do_reset();
        run(6, 0);
        n_checks++;
        if ({s_pclk[5], s_vs[5], s_href[5], s_d[5], s_rdy[5], s_fd[5], s_uf[5]} !== 10'd0)
            $display("FAIL reset_outputs got %b want 0", {s_pclk[5], s_vs[5], s_href[5], s_d[5], s_rdy[5], s_fd[5], s_uf[5]});
        else n_pass++;
        ones = 0;
        for (int i = 0; i < 6; i++) ones += int'(s_pclk[i]);
        n_checks++;
        if (ones !== 0) $display("FAIL idle_pclk got %0d high samples want 0", ones);
        else n_pass++;
    endtask

    task automatic test_frame();
        int first_p, first_v, n_v, n_h0, n_h1, rises, n_fd, fd_at, late_p, dbad;
        do_reset();
        for (int k = 0; k < 16; k++) pix_tab[k] = 8'(k * 17);
        enable = 1'b1;
        run(130, 1);
        first_p = -1; first_v = -1; n_v = 0; n_h0 = 0; n_h1 = 0; rises = 0;
        n_fd = 0; fd_at = -1; late_p = 0; dbad = 0;
        for (int i = 0; i < 130; i++) begin
            if (s_pclk[i] && first_p < 0) first_p = i;
            if (s_vs[i] && first_v < 0) first_v = i;
            n_v += int'(s_vs[i]);
            if (i < 60) n_h0 += int'(s_href[i]); else n_h1 += int'(s_href[i]);
            if (i > 0 && s_href[i] && !s_href[i-1]) rises++;
            if (s_fd[i]) begin n_fd++; fd_at = i; end
            if (i >= 102) late_p += int'(s_pclk[i]);
            if (!s_href[i] && s_d[i] != 4'h0) dbad++;
        end
        n_checks++;
        if (first_p !== 1) $display("FAIL first_pclk got %0d want 1", first_p); else n_pass++;
        n_checks++;
        if (first_v !== 2) $display("FAIL first_vsync got %0d want 2", first_v); else n_pass++;
        n_checks++;
        if (n_v !== 20) $display("FAIL vsync_len got %0d want 20", n_v); else n_pass++;
        n_checks++;
        if (rises !== 2) $display("FAIL href_lines got %0d want 2", rises); else n_pass++;
        n_checks++;
        if (n_h0 !== 16 || n_h1 !== 16) $display("FAIL href_len got %0d,%0d want 16,16", n_h0, n_h1); else n_pass++;
        n_checks++;
        if (n_fd !== 1) $display("FAIL frame_done_count got %0d want 1", n_fd); else n_pass++;
        n_checks++;
        if (fd_at - first_v !== 100) $display("FAIL frame_done_time got %0d want 100", fd_at - first_v); else n_pass++;
        n_checks++;
        if (late_p !== 0) $display("FAIL idle_after_frame got %0d pclk-high samples want 0", late_p); else n_pass++;
        n_checks++;
        if (dbad !== 0) $display("FAIL d_zero_blank got %0d bad samples want 0", dbad); else n_pass++;
    endtask

    task automatic test_stream();
        logic [3:0] exp_n;
        int n_r, dbl;
        do_reset();
        pix_tab[0] = 8'hA5; pix_tab[1] = 8'h3C; pix_tab[2] = 8'h5A; pix_tab[3] = 8'hC3;
        pix_tab[4] = 8'h11; pix_tab[5] = 8'h22; pix_tab[6] = 8'h33; pix_tab[7] = 8'h44;
        enable = 1'b1;
        run(106, 0);
        get_nibbles(102);
        n_checks++;
        if (n_nib !== 16) $display("FAIL stream_nibble_count got %0d want 16", n_nib); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            exp_n = (k % 2 == 0) ? pix_tab[k/2][7:4] : pix_tab[k/2][3:0];
            n_checks++;
            if (nib[k] !== exp_n) $display("FAIL stream_nibble_%0d got %h want %h", k, nib[k], exp_n);
            else n_pass++;
        end
        n_r = 0; dbl = 0;
        for (int i = 0; i < 102; i++) begin
            n_r += int'(s_rdy[i]);
            if (i > 0 && s_rdy[i] && s_rdy[i-1]) dbl++;
        end
        n_checks++;
        if (n_r !== 8 || dbl !== 0) $display("FAIL ready_pulses got %0d (%0d wide) want 8 (0)", n_r, dbl); else n_pass++;
        n_checks++;
        if (s_rdy[41] !== 1'b1) $display("FAIL ready_latency got %b want 1 at sample 41", s_rdy[41]); else n_pass++;
        n_checks++;
        if (s_uf[105] !== 1'b0) $display("FAIL stream_underflow got %b want 0", s_uf[105]); else n_pass++;
        n_checks++;
        if ({s_fd[102], s_vs[102]} !== 2'b11) $display("FAIL back_to_back got %b want 11", {s_fd[102], s_vs[102]}); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        drop_idx = 2;
        enable = 1'b1;
        run(220, 0);
        get_nibbles(102);
        n_checks++;
        if ({nib[3], nib[4], nib[5], nib[6]} !== 16'hC00C)
            $display("FAIL underflow_data got %h want c00c", {nib[3], nib[4], nib[5], nib[6]});
        else n_pass++;
        n_checks++;
        if ({s_uf[49], s_uf[50], s_uf[219]} !== 3'b011)
            $display("FAIL underflow_flag got %b want 011", {s_uf[49], s_uf[50], s_uf[219]});
        else n_pass++;
        do_reset();
        n_checks++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_pattern();
        int n_r;
        do_reset();
        for (int k = 0; k < 16; k++) pix_tab[k] = 8'(8'h10 * k + k);
        pattern_sel = 1'b1;
        enable = 1'b1;
`ifdef CAM_TX_PATTERN_EN
        drop_idx = 0;
`endif
        run(104, 0);
        get_nibbles(102);
        n_r = 0;
        for (int i = 0; i < 102; i++) n_r += int'(s_rdy[i]);
`ifdef CAM_TX_PATTERN_EN
        n_checks++;
        if ({nib[8], nib[9], nib[10], nib[11], nib[12], nib[13], nib[14], nib[15]} !== 32'h01112131)
            $display("FAIL pattern_line1 got %h want 01112131", {nib[8], nib[9], nib[10], nib[11], nib[12], nib[13], nib[14], nib[15]});
        else n_pass++;
        n_checks++;
        if (n_r !== 0 || s_uf[103] !== 1'b0) $display("FAIL pattern_ready got %0d uf %b want 0 0", n_r, s_uf[103]); else n_pass++;
`else
        n_checks++;
        if ({nib[8], nib[9], nib[10], nib[11], nib[12], nib[13], nib[14], nib[15]} !== 32'h44556677)
            $display("FAIL pattern_ignored got %h want 44556677", {nib[8], nib[9], nib[10], nib[11], nib[12], nib[13], nib[14], nib[15]});
        else n_pass++;
        n_checks++;
        if (n_r !== 8) $display("FAIL pattern_ignored_ready got %0d want 8", n_r); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1;
        run(50, 0);
        n_checks++;
        if (s_href[49] !== 1'b1) $display("FAIL mid_act got %b want 1", s_href[49]); else n_pass++;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({PCLK, VSYNC, HREF, D, pix_ready, frame_done, underflow} !== 10'd0)
            $display("FAIL mid_reset got %b want 0", {PCLK, VSYNC, HREF, D, pix_ready, frame_done, underflow});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        run(30, 0);
        n_checks++;
        if ({s_pclk[1], s_vs[1], s_vs[2]} !== 3'b101)
            $display("FAIL restart_vs got %b want 101", {s_pclk[1], s_vs[1], s_vs[2]});
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int vr, hr, n_fd, late_p;
        do_reset();
        enable = 1'b1;
        run(200, 30);
        vr = 0; hr = 0; n_fd = 0; late_p = 0;
        for (int i = 1; i < 200; i++) begin
            if (s_vs[i] && !s_vs[i-1]) vr++;
            if (s_href[i] && !s_href[i-1]) hr++;
            n_fd += int'(s_fd[i]);
            if (i >= 110) late_p += int'(s_pclk[i]);
        end
        n_checks++;
        if (hr !== 2 || n_fd !== 1) $display("FAIL drop_completes got %0d lines %0d done want 2 1", hr, n_fd); else n_pass++;
        n_checks++;
        if (vr !== 1 || late_p !== 0) $display("FAIL drop_stops got %0d vsync %0d pclk want 1 0", vr, late_p); else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) pix_tab[k] = 8'h00;
        pix_data = 8'h00; pix_valid = 1'b0;
        test_reset();
        test_frame();
        test_stream();
        test_underflow();
        test_pattern();
        test_reset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_tx_gen.md
CAM_TX_GEN -- requirements
Module: cam_tx_gen

Interface
- REQ-001 SHALL have parameter H_ACTIVE, default 640: pixels per active line.
- REQ-002 SHALL have parameter H_BLANK, default 144: nibble slots with HREF low after each line.
- REQ-003 SHALL have parameters V_ACTIVE (default 480), VSYNC_LINES (default 3), V_BP (default 17) and V_FP (default 10): line counts per frame region.
- REQ-004 SHALL have port clk, input, 1: sole clock. Reset is synchronous and active-high.
- REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
- REQ-006 SHALL have port enable, input, 1: start/continue frame generation.
- REQ-007 SHALL have port pattern_sel, input, 1: 1 selects the internal test pattern (see Configuration).
- REQ-008 SHALL have ports pix_data (input, 8: pixel), pix_valid (input, 1) and pix_ready (output, 1): pixel stream handshake.
- REQ-009 SHALL have ports PCLK, VSYNC and HREF (output, 1 each) and D (output, 4): camera-side bus, same protocol the capture path receives.
- REQ-010 SHALL have ports frame_done (output, 1: single-cycle pulse) and underflow (output, 1: sticky flag).

Function
- REQ-011 PCLK SHALL be a register that toggles every clk while the FSM is not IDLE and is held 0 in IDLE; one "slot" = 2 clk.
- REQ-012 D, HREF and VSYNC SHALL update only in the cycle where PCLK transitions 1->0, so they are stable across the rising edge.
- REQ-013 Each pixel SHALL occupy two consecutive slots: pix[7:4] first, then pix[3:0].
- REQ-014 FSM states SHALL be IDLE, VS, VBP, ACT, VFP. Transitions: IDLE->VS when enable=1; VS->VBP after VSYNC_LINES lines; VBP->ACT after V_BP lines; ACT->VFP after V_ACTIVE lines; VFP->VS if enable=1 else IDLE, after V_FP lines.
- REQ-015 Every line in every non-IDLE state SHALL be 2*H_ACTIVE+H_BLANK slots long.
- REQ-016 VSYNC SHALL be 1 for all VS slots and 0 otherwise. HREF SHALL be 1 only for the first 2*H_ACTIVE slots of ACT lines.
- REQ-017 D SHALL be 0 whenever HREF=0.
- REQ-018 In stream mode, pix_ready SHALL be a one-clk pulse in the cycle before each high-nibble slot update. The pixel is accepted if pix_valid=1 in that cycle.
- REQ-019 If pix_valid=0 at that cycle, the pixel SHALL be sent as 0x00 and underflow SHALL set. underflow is cleared only by rst.
- REQ-020 frame_done SHALL pulse for one clk on the VFP->VS/IDLE transition.
- REQ-021 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes through VFP, then the FSM goes to IDLE.
- REQ-022 Line and slot counters SHALL wrap to 0 at region/line end with no dead cycle between lines or frames.

Reset
- REQ-023 rst SHALL force state IDLE, all counters 0, and PCLK, VSYNC, HREF, D, pix_ready, frame_done and underflow all 0, on the next clk edge, including mid-frame.
- REQ-024 After rst is released, the first VSYNC rise SHALL occur at the first PCLK falling edge following enable=1.

Configuration
- REQ-025 Macro CAM_TX_PATTERN_EN SHALL control the test-pattern feature.
  - Defined: pattern_sel=1 sends pixel {x[3:0],y[3:0]} (x = pixel index in line, y = active line index). In this mode pix_ready stays 0 and underflow never sets.
  - Undefined: pattern_sel is ignored, stream mode is always used, and the pattern logic is absent.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, VSYNC_LINES=1, V_BP=1, V_FP=1; each line is 10 slots = 20 clk, each frame 5 lines = 100 clk)
- REQ-026 Pulse enable for one cycle -> VSYNC high for exactly 20 clk, HREF high twice for 16 clk each, frame_done one pulse 100 clk after the first PCLK edge, then IDLE with PCLK=0.
- REQ-027 Hold enable=1 and pix_valid=1, streaming 0xA5,0x3C,... -> D sequence on HREF slots is A,5,3,C,...; pix_ready pulses 8 times per frame; underflow=0.
- REQ-028 Drop pix_valid for the 3rd pixel -> that pixel is sent as D=0,0, underflow=1 and stays 1 until rst.
- REQ-029 With CAM_TX_PATTERN_EN and pattern_sel=1 -> line 1 D = 0,1,1,1,2,1,3,1; pix_ready never asserts.
- REQ-030 Assert rst in the middle of ACT -> the next cycle all outputs are 0 and state is IDLE; with enable held high, a new frame restarts from VS.
- REQ-031 Drop enable during VBP -> the frame completes (2 HREF lines, frame_done pulses) and no further VSYNC occurs.
